// File: rtl/rv32_mem_pkg.sv
// Shared RV32 memory-access definitions: funct3 codes, LSU bank FSM states,
// and the store byte-lane mask helper.
package rv32_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Byte lanes touched by an access of the given size at the given offset.
    function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] off);
        logic [3:0] m;
        m = 4'b0000;
        case (funct3[1:0])
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = off[1] ? 4'b1100 : 4'b0011;
            2'b10:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Combinational load aligner: picks byte/halfword by offset (little-endian)
// and sign- or zero-extends according to funct3.
module dmem_load_align
    import rv32_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        shifted  = word >> {off, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = off[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   result = {24'h0, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_HU:   result = {16'h0, half_sel};
            F3_W:    result = word;
            default: result = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_lsu_bank.sv
// RV32I data memory bank with valid/ready request/response, one transaction
// in flight. Optional range check enabled by DMEM_BOUNDS_CHECK_EN.
module dmem_lsu_bank
    import rv32_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] INIT_WORD0   = 32'hAABB_CCDD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        resp_store
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

    logic [31:0] mem [DEPTH_WORDS] = '{0: INIT_WORD0, default: 32'h0};

    state_t      state, state_nxt;
    logic [1:0]  cnt;
    logic        we_q, fault_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [31:0] word_q;
    logic [31:0] aligned;

    logic [31:0]      rel;
    logic [IDX_W-1:0] idx;
    logic [1:0]       off;
    logic             oob, misaligned, bad_f3, fault, accept;
    logic [3:0]       mask;
    logic [31:0]      wdata_rep;
    logic             unused_hi;

    assign rel       = req_addr - BASE_ADDR;
    assign idx       = rel[IDX_W+1:2];
    assign off       = req_addr[1:0];
    assign unused_hi = |rel[31:IDX_W+2];

`ifdef DMEM_BOUNDS_CHECK_EN
    assign oob = |rel[31:IDX_W+2];
`else
    assign oob = 1'b0;
`endif

    always_comb begin
        misaligned = 1'b0;
        case (req_funct3[1:0])
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = |off;
            default: misaligned = 1'b0;
        endcase
        if (req_we)
            bad_f3 = !(req_funct3 inside {F3_B, F3_H, F3_W});
        else
            bad_f3 = !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    end

    assign fault  = misaligned | bad_f3 | oob;
    assign accept = (state == IDLE) && req_valid && !rst;
    assign mask   = lane_mask(req_funct3, off);

    always_comb begin
        case (req_funct3[1:0])
            2'b00:   wdata_rep = {4{req_wdata[7:0]}};
            2'b01:   wdata_rep = {2{req_wdata[15:0]}};
            default: wdata_rep = req_wdata;
        endcase
    end

    // Array has no reset; writes only on an accepted, fault-free store.
    always_ff @(posedge clk) begin
        if (accept && req_we && !fault) begin
            for (int b = 0; b < 4; b++)
                if (mask[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid)
                      state_nxt = (fault || req_we || READ_LATENCY == 1) ? RESP : WAIT;
            WAIT: if (cnt == 2'd1) state_nxt = RESP;
            RESP: if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Transaction capture; word is sampled before any same-edge store lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 2'd0;
            we_q     <= 1'b0;
            fault_q  <= 1'b0;
            funct3_q <= 3'd0;
            off_q    <= 2'd0;
            word_q   <= 32'h0;
        end else if (accept) begin
            cnt      <= CNT_INIT;
            we_q     <= req_we;
            fault_q  <= fault;
            funct3_q <= req_funct3;
            off_q    <= off;
            word_q   <= mem[idx];
        end else if (state == WAIT) begin
            cnt <= cnt - 2'd1;
        end
    end

    dmem_load_align u_align (
        .word   (word_q),
        .off    (off_q),
        .funct3 (funct3_q),
        .result (aligned)
    );

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        resp_fault = resp_valid && fault_q;
        resp_store = resp_valid && we_q;
        resp_rdata = (resp_valid && !we_q && !fault_q) ? aligned : 32'h0;
    end

endmodule
